// File: rtl/imem_ctrl_arb.sv
// Instruction RAM controller/arbiter: BOOT (loader-only writes, CPU held) then RUN (fetch/loader share one port).
// Latency: grants combinational, read data and rvalid one cycle after accept; addr_err one cycle after accept.
// Backpressure: a requester holds req until gnt; fetch has priority in RUN, loader is force-granted after STARVE_LIMIT losses.
// Optional feature: define IMEM_CTRL_WRLOCK_EN to suppress and flag loader writes once in RUN.
module imem_ctrl_arb #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int MEM_SIZE     = 512,
   parameter int STARVE_LIMIT = 4,
   localparam int IDX_W       = $clog2(MEM_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_gnt,
   output logic                  fetch_rvalid,
   output logic [DATA_WIDTH-1:0] fetch_rdata,
   input  logic                  ld_req,
   input  logic                  ld_we,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_wdata,
   input  logic                  ld_done,
   output logic                  ld_gnt,
   output logic                  ld_rvalid,
   output logic [DATA_WIDTH-1:0] ld_rdata,
   output logic                  cpu_hold,
   output logic                  addr_err,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [IDX_W-1:0]      mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [DATA_WIDTH-1:0] NOP_INSN = DATA_WIDTH'(32'h0000_0013);
   localparam logic [ADDR_WIDTH:0]   BYTE_LIMIT = (ADDR_WIDTH + 1)'(4 * MEM_SIZE);
   localparam logic [CNT_W-1:0]      STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic {BOOT, RUN} state_t;

   state_t           state;
   logic [CNT_W-1:0] starve_cnt;
   logic             in_run;
   logic             starved;
   logic             fetch_err;
   logic             ld_range_err;
   logic             ld_misalign;
   logic             ld_lock;
   logic             ld_err;
   logic             ld_rd_acc;

   assign in_run  = (state == RUN);
   assign starved = (starve_cnt == STARVE_MAX);

   assign fetch_gnt = in_run && fetch_req && !(ld_req && starved);
   assign ld_gnt    = ld_req && (!in_run || !fetch_req || starved);
   assign ld_rd_acc = ld_gnt && !ld_we;

   assign fetch_err    = ({1'b0, fetch_addr} >= BYTE_LIMIT);
   assign ld_range_err = ({1'b0, ld_addr} >= BYTE_LIMIT);
   assign ld_misalign  = ld_we && (ld_addr[1:0] != 2'b00);
`ifdef IMEM_CTRL_WRLOCK_EN
   assign ld_lock      = in_run && ld_we;
`else
   assign ld_lock      = 1'b0;
`endif
   assign ld_err       = ld_range_err || ld_misalign || ld_lock;

   // Erroneous accesses are still granted but never reach the RAM.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = fetch_addr[IDX_W+1:2];
      mem_wdata = ld_wdata;
      if (fetch_gnt) begin
         mem_en = !fetch_err;
      end else if (ld_gnt) begin
         mem_addr = ld_addr[IDX_W+1:2];
         mem_en   = !ld_err;
         mem_we   = ld_we && !ld_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= BOOT;
         cpu_hold     <= 1'b1;
         starve_cnt   <= '0;
         fetch_rvalid <= 1'b0;
         fetch_rdata  <= '0;
         ld_rvalid    <= 1'b0;
         ld_rdata     <= '0;
         addr_err     <= 1'b0;
      end else begin
         case (state)
            BOOT: if (ld_done) begin
               state    <= RUN;
               cpu_hold <= 1'b0;
            end
            RUN:  cpu_hold <= 1'b0;
            default: begin
               state    <= BOOT;
               cpu_hold <= 1'b1;
            end
         endcase

         // Counts consecutive RUN cycles the loader asked and lost; starved implies the loader wins.
         if (in_run && ld_req && !ld_gnt) begin
            if (!starved) starve_cnt <= starve_cnt + 1'b1;
         end else begin
            starve_cnt <= '0;
         end

         fetch_rvalid <= fetch_gnt;
         if (fetch_gnt) fetch_rdata <= fetch_err ? NOP_INSN : mem_rdata;

         ld_rvalid <= ld_rd_acc;
         if (ld_rd_acc) ld_rdata <= ld_err ? NOP_INSN : mem_rdata;

         addr_err <= (fetch_gnt && fetch_err) || (ld_gnt && ld_err);
      end
   end

endmodule

// File: tb/tb_imem_ctrl_arb.sv
// Randomized scoreboard bench for imem_ctrl_arb: a word-array reference model predicts grants,
// RAM strobes, read data and addr_err; a negedge monitor pops expected responses as they appear.
module tb_imem_ctrl_arb;
   localparam int LIMIT = 4;
`ifdef IMEM_CTRL_WRLOCK_EN
   localparam bit WRLOCK = 1'b1;
`else
   localparam bit WRLOCK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req, fetch_gnt, fetch_rvalid;
   logic [31:0] fetch_addr, fetch_rdata;
   logic        ld_req, ld_we, ld_done, ld_gnt, ld_rvalid;
   logic [31:0] ld_addr, ld_wdata, ld_rdata;
   logic        cpu_hold, addr_err, mem_en, mem_we;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   imem_ctrl_arb #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(512), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_done(ld_done),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
      .cpu_hold(cpu_hold), .addr_err(addr_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Instruction RAM attached to the DUT port
   logic [31:0] ram [0:511];
   assign mem_rdata = ram[mem_addr];
   always @(posedge clk) if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;

   typedef struct {int due; logic [31:0] dat;} exp_t;
   exp_t        fq[$];
   exp_t        lq[$];
   int          eq[$];
   logic [31:0] model_mem [0:511];
   bit          run;
   int          lost;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rnd_addr();
      case ($urandom_range(0, 9))
         0:       return 32'h0000_07FC;
         1:       return 32'h0000_0800 + (32'($urandom_range(0, 3)) << 2);
         2:       return 32'hFFFF_FFFC;
         3:       return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
         default: return 32'($urandom_range(0, 63)) << 2;
      endcase
   endfunction

   // One cycle of stimulus plus the model's prediction of that cycle's grants and RAM strobes.
   task automatic step(input bit fr, input logic [31:0] fa, input bit lr, input bit lwe,
                       input logic [31:0] la, input logic [31:0] lwd, input bit ldn);
      bit fg, lg, err;
      int idx;
      @(posedge clk);
      #1;
      fetch_req = fr; fetch_addr = fa;
      ld_req = lr; ld_we = lwe; ld_addr = la; ld_wdata = lwd; ld_done = ldn;
      #1;
      fg = run && fr && !(lr && lost == LIMIT);
      lg = lr && !fg;
      chk("fetch_gnt", fetch_gnt, fg);
      chk("ld_gnt", ld_gnt, lg);
      chk("cpu_hold", cpu_hold, !run);
      if (fg) begin
         err = (fa >= 32'h800);
         idx = int'(fa[10:2]);
         fq.push_back('{cyc + 1, err ? 32'h13 : model_mem[idx]});
         chk("fetch mem_en", mem_en, !err);
         if (!err) chk("fetch mem_addr", mem_addr, 32'(idx));
         if (err) eq.push_back(cyc + 1);
      end else if (lg) begin
         err = (la >= 32'h800) || (lwe && la[1:0] != 2'b00) || (WRLOCK && run && lwe);
         idx = int'(la[10:2]);
         chk("ld mem_en", mem_en, !err);
         chk("ld mem_we", mem_we, lwe && !err);
         if (!err) chk("ld mem_addr", mem_addr, 32'(idx));
         if (lwe) begin
            if (!err) model_mem[idx] = lwd;
         end else begin
            lq.push_back('{cyc + 1, err ? 32'h13 : model_mem[idx]});
         end
         if (err) eq.push_back(cyc + 1);
      end else begin
         chk("idle mem_en", mem_en, 0);
      end
      if (run) lost = (lr && !lg) ? ((lost < LIMIT) ? lost + 1 : LIMIT) : 0;
      if (!run && ldn) run = 1'b1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      bit   ee;
      if (mon_en) begin
         if (fetch_rvalid) begin
            if (fq.size() == 0) chk("fetch_rvalid spurious", fetch_rvalid, 0);
            else begin
               e = fq.pop_front();
               chk("fetch_rvalid timing", cyc, e.due);
               chk("fetch_rdata", fetch_rdata, e.dat);
            end
         end else if (fq.size() != 0 && fq[0].due <= cyc) begin
            void'(fq.pop_front());
            chk("fetch_rvalid missing", fetch_rvalid, 1);
         end
         if (ld_rvalid) begin
            if (lq.size() == 0) chk("ld_rvalid spurious", ld_rvalid, 0);
            else begin
               e = lq.pop_front();
               chk("ld_rvalid timing", cyc, e.due);
               chk("ld_rdata", ld_rdata, e.dat);
            end
         end else if (lq.size() != 0 && lq[0].due <= cyc) begin
            void'(lq.pop_front());
            chk("ld_rvalid missing", ld_rvalid, 1);
         end
         ee = (eq.size() != 0) && (eq[0] == cyc);
         if (ee) void'(eq.pop_front());
         chk("addr_err", addr_err, ee);
      end
   end

   task automatic boot_load(input int words);
      for (int i = 0; i < words; i++) step(1'b1, 32'h0, 1'b1, 1'b1, 32'(i) << 2, $urandom, 1'b0);
      step(1'b1, 32'h0, 1'b1, 1'b1, 32'h7FC, $urandom, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h6, 32'hBAD0_0006, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
      step(1'b1, 32'h0, 1'b1, 1'b1, 32'h100, $urandom, 1'b1);
   endtask

   task automatic rand_run(input int n);
      for (int i = 0; i < n; i++)
         step(($urandom_range(0, 3) != 0), rnd_addr(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'($urandom_range(0, 7) == 0));
   endtask

   initial begin
      rst_n = 1'b0;
      fetch_req = 0; fetch_addr = 0; ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_done = 0;
      run = 1'b0; lost = 0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset cpu_hold", cpu_hold, 1);
      chk("reset fetch_gnt", fetch_gnt, 0);
      chk("reset ld_gnt", ld_gnt, 0);
      chk("reset fetch_rvalid", fetch_rvalid, 0);
      chk("reset ld_rvalid", ld_rvalid, 0);
      chk("reset addr_err", addr_err, 0);
      chk("reset mem_en", mem_en, 0);
      chk("reset mem_we", mem_we, 0);
      chk("reset fetch_rdata", fetch_rdata, 0);
      chk("reset ld_rdata", ld_rdata, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 mon_en = 1'b1;

      boot_load(64);
      step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, 32'(i) << 2, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
      step(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h6, 32'h1234_5678, 1'b0);
      step(1'b1, 32'h7FE, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h804, 32'h0, 1'b0);
      rand_run(400);

      // Reset lands between the accept edge and the rvalid cycle.
      step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      rst_n = 1'b0;
      mon_en = 1'b0;
      fetch_req = 0; ld_req = 0; ld_we = 0; ld_done = 0;
      fq.delete(); lq.delete(); eq.delete();
      run = 1'b0; lost = 0;
      #1;
      chk("mid-reset cpu_hold", cpu_hold, 1);
      chk("mid-reset fetch_rvalid", fetch_rvalid, 0);
      @(posedge clk);
      #2;
      chk("mid-reset rvalid lost", fetch_rvalid, 0);
      chk("mid-reset addr_err", addr_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 mon_en = 1'b1;

      boot_load(8);
      rand_run(250);
      repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("fetch queue drained", fq.size(), 0);
      chk("ld queue drained", lq.size(), 0);
      chk("addr_err queue drained", eq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
